// File: rtl/taxi_pkg.sv
// Shared types and BCD fare constants for the taxi meter trip sequencer.
// Contents: trip state enum, day/night fare constants, and a single-digit
// BCD add helper used by the fare adder.
package taxi_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    WAIT = 3'd2,
    DONE = 3'd3
  } state_e;

  // BCD fares in tenths of a yuan: {hundreds, tens, units, tenths}
  localparam logic [15:0] BASE_FARE  = 16'h0100;
  localparam logic [15:0] KM_RATE    = 16'h0020;
  localparam logic [15:0] WAIT_RATE  = 16'h0010;
  localparam logic [15:0] NIGHT_BASE = 16'h0130;
  localparam logic [15:0] NIGHT_KM   = 16'h0030;
  localparam logic [15:0] FARE_MAX   = 16'h9999;

  // One BCD digit add with carry: returns {carry_out, digit}.
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] a,
                                               input logic [3:0] b,
                                               input logic       cin);
    logic [4:0] raw;
    logic [3:0] adj;
    raw = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    adj = raw[3:0] + 4'd6;
    return (raw > 5'd9) ? {1'b1, adj} : raw;
  endfunction

endpackage

// File: rtl/taxi_trip_ctrl_bcd_add4.sv
// bcd_add4: 4-digit BCD adder, ripple carry between digits.
// Ports:
//   a, b : 16-bit BCD operands
//   sum  : 16-bit BCD sum (low four digits, meaningless when sat=1)
//   sat  : carry out of the top digit; caller substitutes FARE_MAX
module bcd_add4
  import taxi_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum,
  output logic        sat
);

  logic [4:0] d0_s;
  logic [4:0] d1_s;
  logic [4:0] d2_s;
  logic [4:0] d3_s;

  assign d0_s = bcd_digit_add(a[3:0],   b[3:0],   1'b0);
  assign d1_s = bcd_digit_add(a[7:4],   b[7:4],   d0_s[4]);
  assign d2_s = bcd_digit_add(a[11:8],  b[11:8],  d1_s[4]);
  assign d3_s = bcd_digit_add(a[15:12], b[15:12], d2_s[4]);

  assign sum = {d3_s[3:0], d2_s[3:0], d1_s[3:0], d0_s[3:0]};
  assign sat = d3_s[4];

endmodule

// File: rtl/taxi_trip_ctrl.sv
// taxi_trip_ctrl: trip sequencer for the taxi meter.
// Tracks IDLE/RUN/WAIT/DONE, detects a stationary vehicle, drives the
// wait_time counter's enable/clear, and accumulates a 4-digit BCD fare from
// distance (wheel pulses) and chargeable wait minutes.
// Optional build macro NIGHT_RATE_EN adds input 'night' selecting night rates.
// Ports:
//   clk, reset (async active-low)
//   start_btn, end_btn, wheel_pulse, sec_tick : 1-cycle strobes
//   wait_m     : BCD minutes digit from the wait_time counter
//   wait_en    : wait_time count enable (high only in WAIT)
//   wait_rst_n : wait_time sync clear (low in IDLE and first RUN cycle)
//   fare       : BCD fare {hundreds,tens,units,tenths}
//   km         : BCD whole km, saturating at 99
//   state      : current state encoding (taxi_pkg::state_e)
module taxi_trip_ctrl
  import taxi_pkg::*;
#(
  parameter int unsigned STILL_SEC     = 3,
  parameter int unsigned FREE_KM       = 3,
  parameter int unsigned FREE_WAIT_MIN = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_btn,
  input  logic        end_btn,
  input  logic        wheel_pulse,
  input  logic        sec_tick,
`ifdef NIGHT_RATE_EN
  input  logic        night,
`endif
  input  logic [3:0]  wait_m,
  output logic        wait_en,
  output logic        wait_rst_n,
  output logic [15:0] fare,
  output logic [7:0]  km,
  output logic [2:0]  state
);

  localparam logic [3:0] STILL_MAX   = 4'(STILL_SEC);
  localparam logic [7:0] FREE_KM_BCD = 8'(FREE_KM);
  localparam logic [6:0] FREE_WAIT   = 7'(FREE_WAIT_MIN);

  state_e      state_r,  state_nxt_s;
  logic [15:0] fare_r,   fare_nxt_s;
  logic [7:0]  km_r,     km_nxt_s;
  logic [3:0]  hm_r,     hm_nxt_s;
  logic [3:0]  still_r,  still_nxt_s;
  logic [6:0]  wmin_r,   wmin_nxt_s;
  logic        first_r,  first_nxt_s;
  logic [3:0]  prev_m_r;
  logic        wait_en_r, wait_rst_n_r;

  logic        active_s, km_wrap_s, km_charge_s, minute_s, wait_charge_s;
  logic [3:0]  still_inc_s;
  logic [15:0] incr_s, sum_s, base_s, km_rate_s;
  logic        sat_s;

`ifdef NIGHT_RATE_EN
  assign base_s    = night ? NIGHT_BASE : BASE_FARE;
  assign km_rate_s = night ? NIGHT_KM   : KM_RATE;
`else
  assign base_s    = BASE_FARE;
  assign km_rate_s = KM_RATE;
`endif

  assign active_s      = (state_r == RUN) || (state_r == WAIT);
  assign km_wrap_s     = wheel_pulse && (hm_r == 4'd9);
  assign km_charge_s   = active_s && km_wrap_s && (km_r >= FREE_KM_BCD);
  // first_r marks the cycle the timer is being cleared; its minute digit is stale
  assign minute_s      = active_s && !first_r && (wait_m != prev_m_r);
  assign wait_charge_s = minute_s && (wmin_r >= FREE_WAIT);
  // Rates only occupy the tens digit and sum to at most 4, so plain binary add is valid BCD
  assign incr_s = (km_charge_s   ? km_rate_s : 16'h0000)
                + (wait_charge_s ? WAIT_RATE : 16'h0000);
  assign still_inc_s = wheel_pulse ? 4'd0 :
                       (sec_tick && (still_r != STILL_MAX)) ? still_r + 4'd1 : still_r;

  bcd_add4 u_add (
    .a   (fare_r),
    .b   (incr_s),
    .sum (sum_s),
    .sat (sat_s)
  );

  // Next-state and datapath update for the trip sequencer
  always_comb begin
    state_nxt_s = state_r;
    fare_nxt_s  = fare_r;
    km_nxt_s    = km_r;
    hm_nxt_s    = hm_r;
    still_nxt_s = still_r;
    wmin_nxt_s  = wmin_r;
    first_nxt_s = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start_btn) begin
          state_nxt_s = RUN;
          fare_nxt_s  = base_s;
          km_nxt_s    = 8'h00;
          hm_nxt_s    = 4'd0;
          still_nxt_s = 4'd0;
          wmin_nxt_s  = 7'd0;
          first_nxt_s = 1'b1;
        end else begin
          state_nxt_s = state_r;
        end
      end
      RUN, WAIT: begin
        if (end_btn) begin
          state_nxt_s = DONE;
        end else begin
          fare_nxt_s  = sat_s ? FARE_MAX : sum_s;
          still_nxt_s = still_inc_s;
          if (wheel_pulse) begin
            hm_nxt_s = km_wrap_s ? 4'd0 : hm_r + 4'd1;
          end else begin
            hm_nxt_s = hm_r;
          end
          if (km_wrap_s && (km_r != 8'h99)) begin
            km_nxt_s = (km_r[3:0] == 4'd9) ? {km_r[7:4] + 4'd1, 4'd0} : km_r + 8'd1;
          end else begin
            km_nxt_s = km_r;
          end
          if (minute_s && (wmin_r != 7'd99)) begin
            wmin_nxt_s = wmin_r + 7'd1;
          end else begin
            wmin_nxt_s = wmin_r;
          end
          if (state_r == RUN) begin
            state_nxt_s = (still_inc_s == STILL_MAX) ? WAIT : RUN;
          end else begin
            state_nxt_s = wheel_pulse ? RUN : WAIT;
          end
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, datapath and registered timer-control outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      fare_r       <= 16'h0000;
      km_r         <= 8'h00;
      hm_r         <= 4'd0;
      still_r      <= 4'd0;
      wmin_r       <= 7'd0;
      first_r      <= 1'b0;
      prev_m_r     <= 4'd0;
      wait_en_r    <= 1'b0;
      wait_rst_n_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      fare_r       <= fare_nxt_s;
      km_r         <= km_nxt_s;
      hm_r         <= hm_nxt_s;
      still_r      <= still_nxt_s;
      wmin_r       <= wmin_nxt_s;
      first_r      <= first_nxt_s;
      prev_m_r     <= wait_m;
      wait_en_r    <= (state_nxt_s == WAIT);
      wait_rst_n_r <= !((state_nxt_s == IDLE) || ((state_nxt_s == RUN) && first_nxt_s));
    end
  end

  assign wait_en    = wait_en_r;
  assign wait_rst_n = wait_rst_n_r;
  assign fare       = fare_r;
  assign km         = km_r;
  assign state      = state_r;

endmodule

// File: tb/tb_taxi_trip_ctrl.sv
// Testbench for taxi_trip_ctrl: directed scenarios plus random traffic, with
// expected outputs from a behavioural fare model pushed into a scoreboard
// queue and compared by an independent monitor after every clock edge.
module tb_taxi_trip_ctrl;

  localparam int S_IDLE = 0, S_RUN = 1, S_WAIT = 2, S_DONE = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_btn = 1'b0, end_btn = 1'b0, wheel_pulse = 1'b0, sec_tick = 1'b0;
  logic        night = 1'b0;
  logic [3:0]  wait_m = 4'd0;
  logic        wait_en, wait_rst_n;
  logic [15:0] fare;
  logic [7:0]  km;
  logic [2:0]  state;

  always #5 clk = ~clk;

  taxi_trip_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start_btn   (start_btn),
    .end_btn     (end_btn),
    .wheel_pulse (wheel_pulse),
    .sec_tick    (sec_tick),
`ifdef NIGHT_RATE_EN
    .night       (night),
`endif
    .wait_m      (wait_m),
    .wait_en     (wait_en),
    .wait_rst_n  (wait_rst_n),
    .fare        (fare),
    .km          (km),
    .state       (state)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic [15:0] fare;
    logic [7:0]  km;
    logic        we;
    logic        wr;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;
  string phase = "reset";

  // Behavioural model: fare in tenths, distance as total pulses, minutes as a count
  int m_st = S_IDLE, m_fare = 0, m_pulses = 0, m_still = 0, m_mins = 0, m_prevm = 0;
  bit m_first = 0;

  function automatic logic [15:0] bcd4(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model(input bit rst, input bit s, input bit e, input bit p,
                       input bit t, input int wm, input bit nt_in);
    bit nt, minute;
    int charge;
`ifdef NIGHT_RATE_EN
    nt = nt_in;
`else
    nt = 1'b0 & nt_in;
`endif
    if (!rst) begin
      m_st = S_IDLE; m_fare = 0; m_pulses = 0; m_still = 0; m_mins = 0;
      m_first = 0; m_prevm = 0;
      return;
    end
    minute = (m_st == S_RUN || m_st == S_WAIT) && !m_first && (wm != m_prevm);
    if (m_st == S_IDLE || m_st == S_DONE) begin
      if (s) begin
        m_st = S_RUN; m_fare = nt ? 130 : 100; m_pulses = 0; m_still = 0;
        m_mins = 0; m_first = 1;
      end
    end else if (e) begin
      m_st = S_DONE; m_first = 0;
    end else begin
      charge = 0;
      if (p) begin
        m_pulses++;
        if (m_pulses % 10 == 0 && min_i(m_pulses / 10 - 1, 99) >= 3)
          charge += nt ? 30 : 20;
      end
      if (minute) begin
        if (m_mins >= 5) charge += 10;
        m_mins = min_i(m_mins + 1, 99);
      end
      m_fare = min_i(m_fare + charge, 9999);
      m_still = p ? 0 : (t ? min_i(m_still + 1, 3) : m_still);
      if (m_st == S_RUN && m_still == 3) m_st = S_WAIT;
      else if (m_st == S_WAIT && p) m_st = S_RUN;
      m_first = 0;
    end
    m_prevm = wm;
  endtask

  // Drive one cycle of inputs (called at negedge), update model, queue the expectation
  task automatic step(input bit rst, input bit s, input bit e, input bit p,
                      input bit t, input int wm);
    exp_t ex;
    reset = rst; start_btn = s; end_btn = e; wheel_pulse = p; sec_tick = t;
    wait_m = 4'(wm);
    model(rst, s, e, p, t, wm, night);
    ex.st   = 3'(m_st);
    ex.fare = bcd4(m_fare);
    ex.km   = bcd4(min_i(m_pulses / 10, 99))[7:0];
    ex.we   = (m_st == S_WAIT);
    ex.wr   = !(m_st == S_IDLE || (m_st == S_RUN && m_first));
    exp_q.push_back(ex);
    tag_q.push_back(phase);
    @(negedge clk);
  endtask

  // Monitor: compares DUT outputs against the queued expectation after each edge
  exp_t  mon_ex;
  string mon_tag;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_ex  = exp_q.pop_front();
      mon_tag = tag_q.pop_front();
      checks++;
      if ({state, fare, km, wait_en, wait_rst_n} !== mon_ex) begin
        errors++;
        $display("FAIL %s t=%0t: got state=%0d fare=%h km=%h wait_en=%b wait_rst_n=%b, expected state=%0d fare=%h km=%h wait_en=%b wait_rst_n=%b",
                 mon_tag, $time, state, fare, km, wait_en, wait_rst_n,
                 mon_ex.st, mon_ex.fare, mon_ex.km, mon_ex.we, mon_ex.wr);
      end
    end
  end

  int wm_cur;

  initial begin
    wm_cur = 0;
    @(negedge clk);
    phase = "reset_state";
    repeat (3) step(0, 0, 0, 0, 0, 0);
    phase = "idle";
    repeat (2) step(1, 0, 0, 0, 0, 0);

    // distance: 30 pulses free, next 10 charge one km
    phase = "start";
    step(1, 1, 0, 0, 0, 0);
    phase = "free_km";
    repeat (30) begin step(1, 0, 0, 1, 0, 0); step(1, 0, 0, 0, 0, 0); end
    phase = "first_paid_km";
    repeat (10) step(1, 0, 0, 1, 0, 0);

    // stationary detection and exit on pulse
    phase = "enter_wait";
    repeat (3) begin step(1, 0, 0, 0, 1, 0); step(1, 0, 0, 0, 0, 0); end
    phase = "exit_wait";
    step(1, 0, 0, 1, 0, 0);

    // wait minutes 1..7 in WAIT, then 8,9 and the 9->0 wrap
    phase = "wait_minutes";
    repeat (3) step(1, 0, 0, 0, 1, 0);
    for (int m = 1; m <= 9; m++) step(1, 0, 0, 0, 0, m);
    phase = "minute_wrap";
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    // async reset mid-trip
    phase = "reset_mid_run";
    step(1, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 3);
    step(1, 0, 0, 0, 0, 0);

    // same-cycle km + wait charge, then drive fare into saturation
    phase = "start2";
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    phase = "free_minutes";
    for (int m = 1; m <= 5; m++) step(1, 0, 0, 0, 0, m);
    phase = "km_to_3";
    repeat (39) step(1, 0, 0, 1, 0, 5);
    phase = "km_plus_wait";
    step(1, 0, 0, 1, 0, 6);
    phase = "saturate";
    repeat (4950) step(1, 0, 0, 1, 0, 6);

    // end+start collisions
    phase = "end_wins_run";
    step(1, 1, 1, 0, 0, 6);
    phase = "done_hold";
    step(1, 0, 0, 1, 1, 7);
    phase = "start_wins_done";
    step(1, 1, 1, 0, 0, 7);
    phase = "ignore_start_run";
    step(1, 1, 0, 1, 0, 7);

    // random traffic
    phase = "random";
    repeat (3000) begin
      if ($urandom_range(99) < 10) wm_cur = (wm_cur + 1) % 10;
      night = ($urandom_range(1) == 1);
      step(($urandom_range(499) != 0),
           ($urandom_range(99) < 2), ($urandom_range(99) < 1),
           ($urandom_range(99) < 30), ($urandom_range(99) < 20), wm_cur);
    end
    night = 1'b0;

    // bounded drain of the scoreboard
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
